// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write-back driver.
// After reset it sweeps zeros into registers 1..2^ADDR_W-1 because the register file itself has no reset.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InRegWrite,
  input  logic              InMemtoReg,
  input  logic [ADDR_W-1:0] InWriteRegister,
  input  logic [DATA_W-1:0] InAluResult,
  input  logic [DATA_W-1:0] InMemReadData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              InitDone,
  output logic              FwdValid,
  output logic [ADDR_W-1:0] FwdRegister,
  output logic [DATA_W-1:0] FwdData
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic              reg_write_next;
  logic [ADDR_W-1:0] write_register_next;
  logic [DATA_W-1:0] write_data_next;
  logic              init_done_next;

  // State, sweep counter and all register-file-facing output flops
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= INIT;
      idx           <= IDX_ONE;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      InitDone      <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      RegWrite      <= reg_write_next;
      WriteRegister <= write_register_next;
      WriteData     <= write_data_next;
      InitDone      <= init_done_next;
    end
  end

  // Next-state and next-output selection; pipeline controls are ignored during the sweep
  always_comb begin
    state_next          = state;
    idx_next            = idx;
    reg_write_next      = RegWrite;
    write_register_next = WriteRegister;
    write_data_next     = WriteData;
    init_done_next      = InitDone;
    case (state)
      INIT: begin
        if (idx != '0) begin
          reg_write_next      = 1'b1;
          write_register_next = idx;
          write_data_next     = '0;
          idx_next            = idx + IDX_ONE;
        end else begin
          state_next          = RUN;
          init_done_next      = 1'b1;
          reg_write_next      = 1'b0;
          write_register_next = '0;
          write_data_next     = '0;
        end
      end
      RUN: begin
        if (Flush) begin
          reg_write_next      = 1'b0;
          write_register_next = '0;
          write_data_next     = '0;
        end else if (Stall) begin
          reg_write_next      = RegWrite;
          write_register_next = WriteRegister;
          write_data_next     = WriteData;
        end else begin
          // Writes to register 0 are dropped, but index and data still load for visibility
          reg_write_next      = InRegWrite & (InWriteRegister != '0);
          write_register_next = InWriteRegister;
          write_data_next     = InMemtoReg ? InMemReadData : InAluResult;
        end
      end
      default: begin
        state_next          = INIT;
        idx_next            = IDX_ONE;
        reg_write_next      = 1'b0;
        write_register_next = '0;
        write_data_next     = '0;
        init_done_next      = 1'b0;
      end
    endcase
  end

  assign FwdValid    = RegWrite & InitDone;
  assign FwdRegister = WriteRegister;
  assign FwdData     = WriteData;

endmodule
